// File: rtl/div_pkg.sv
// Shared constants for the restoring divider: default widths, counter width and FSM encoding.
// Pure declarations, no logic.
package div_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_VW = 4;
    localparam int CW     = $clog2(DEF_DW + 1);

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/sub_cmp_stage.sv
// One restoring-division step: compare the shifted partial remainder against the divisor.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module sub_cmp_stage #(
    parameter int VW = 4
) (
    input  logic [VW:0]   p,
    input  logic [VW-1:0] d,
    output logic [VW-1:0] r_next,
    output logic          qbit
);

    // While r < d holds, p - d < d also fits in VW bits, so dropping the top bit is lossless.
    assign qbit   = (p >= {1'b0, d});
    assign r_next = qbit ? VW'(p - {1'b0, d}) : p[VW-1:0];

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Latency: done follows DW cycles after the accepted start (1 cycle for a zero divisor).
// Backpressure: start is only accepted in IDLE/DONE; it is ignored while busy.
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int LCW = $clog2(DW + 1);

    state_t         state;
    logic [DW-1:0]  q_reg;
    logic [VW-1:0]  r_reg;
    logic [VW-1:0]  d_reg;
    logic [LCW-1:0] cnt;

    logic [VW:0]    p;
    logic [VW-1:0]  r_next;
    logic           qbit;
    logic [DW-1:0]  q_next;

    // The working quotient register starts as the dividend; its MSB feeds the remainder each step.
    assign p      = {r_reg, q_reg[DW-1]};
    assign q_next = {q_reg[DW-2:0], qbit};

    sub_cmp_stage #(.VW(VW)) u_stage (
        .p      (p),
        .d      (d_reg),
        .r_next (r_next),
        .qbit   (qbit)
    );

    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= CALC;
                        q_reg <= dividend;
                        d_reg <= divisor;
                        r_reg <= '0;
                        cnt   <= LCW'(DW);
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (d_reg == '0) begin
                        // q_reg is still the untouched dividend here.
                        state       <= DONE;
                        quotient    <= '1;
                        remainder   <= q_reg[VW-1:0];
                        div_by_zero <= 1'b1;
                    end else begin
                        r_reg <= r_next;
                        q_reg <= q_next;
                        cnt   <= cnt - LCW'(1);
                        if (cnt == LCW'(1)) begin
                            state       <= DONE;
                            quotient    <= q_next;
                            remainder   <= r_next;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and exhaustive checks of shift_sub_divider against hand-computed / arithmetic expectations.
module tb_shift_sub_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_cmp;
    int n_bad;

    shift_sub_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic pulse_start(input logic [7:0] a, input logic [3:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output int bcyc);
        cyc  = 0;
        bcyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            if (busy === 1'b1) bcyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (quotient !== 8'd0) begin n_bad++; $display("FAIL reset_quotient got %0d want 0", quotient); end
        n_cmp++; if (remainder !== 4'd0) begin n_bad++; $display("FAIL reset_remainder got %0d want 0", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc, bcyc;
        pulse_start(8'd200, 4'd7);
        wait_done(20, cyc, bcyc);
        n_cmp++; if (done !== 1'b1 || cyc != 8) begin n_bad++; $display("FAIL 200_7_latency got %0d done=%b want 8", cyc, done); end
        n_cmp++; if (bcyc != 8) begin n_bad++; $display("FAIL 200_7_busy_cycles got %0d want 8", bcyc); end
        n_cmp++; if (quotient !== 8'd28) begin n_bad++; $display("FAIL 200_7_quotient got %0d want 28", quotient); end
        n_cmp++; if (remainder !== 4'd4) begin n_bad++; $display("FAIL 200_7_remainder got %0d want 4", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL 200_7_dbz got %b want 0", div_by_zero); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle got %b want 0", done); end
        n_cmp++; if (quotient !== 8'd28) begin n_bad++; $display("FAIL quotient_hold got %0d want 28", quotient); end

        pulse_start(8'd255, 4'd15);
        n_cmp++; if (quotient !== 8'd28 || remainder !== 4'd4) begin
            n_bad++; $display("FAIL prev_visible_busy got q=%0d r=%0d want q=28 r=4", quotient, remainder);
        end
        wait_done(20, cyc, bcyc);
        n_cmp++; if (done !== 1'b1 || quotient !== 8'd17 || remainder !== 4'd0) begin
            n_bad++; $display("FAIL 255_15 got done=%b q=%0d r=%0d want q=17 r=0", done, quotient, remainder);
        end
        @(negedge clk);
        pulse_start(8'd5, 4'd9);
        wait_done(20, cyc, bcyc);
        n_cmp++; if (done !== 1'b1 || quotient !== 8'd0 || remainder !== 4'd5) begin
            n_bad++; $display("FAIL 5_9 got done=%b q=%0d r=%0d want q=0 r=5", done, quotient, remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero;
        int cyc, bcyc;
        pulse_start(8'd100, 4'd0);
        wait_done(20, cyc, bcyc);
        n_cmp++; if (done !== 1'b1 || cyc != 1) begin n_bad++; $display("FAIL div0_latency got %0d done=%b want 1", cyc, done); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_bad++; $display("FAIL div0_flag got %b want 1", div_by_zero); end
        n_cmp++; if (quotient !== 8'hFF) begin n_bad++; $display("FAIL div0_quotient got %0h want ff", quotient); end
        n_cmp++; if (remainder !== 4'd4) begin n_bad++; $display("FAIL div0_remainder got %0d want 4", remainder); end
        @(negedge clk);
        n_cmp++; if (div_by_zero !== 1'b1) begin n_bad++; $display("FAIL div0_flag_hold got %b want 1", div_by_zero); end
    endtask

    task automatic test_start_while_busy;
        int cyc, bcyc;
        pulse_start(8'd200, 4'd7);
        repeat (2) @(negedge clk);
        pulse_start(8'd13, 4'd3);
        wait_done(20, cyc, bcyc);
        n_cmp++; if (done !== 1'b1 || cyc != 5) begin n_bad++; $display("FAIL busy_start_latency got %0d done=%b want 5", cyc, done); end
        n_cmp++; if (quotient !== 8'd28 || remainder !== 4'd4 || div_by_zero !== 1'b0) begin
            n_bad++; $display("FAIL busy_start_ignored got q=%0d r=%0d dbz=%b want q=28 r=4 dbz=0", quotient, remainder, div_by_zero);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc, bcyc, dones;
        pulse_start(8'd200, 4'd7);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (quotient !== 8'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset got q=%0d r=%0d dbz=%b busy=%b done=%b want all 0", quotient, remainder, div_by_zero, busy, done);
        end
        dones = 0;
        repeat (3) begin @(negedge clk); if (done === 1'b1) dones++; end
        rst = 1'b1;
        repeat (10) begin @(negedge clk); if (done === 1'b1) dones++; end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL mid_reset_no_done got %0d want 0", dones); end
        pulse_start(8'd36, 4'd6);
        wait_done(20, cyc, bcyc);
        n_cmp++; if (done !== 1'b1 || quotient !== 8'd6 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            n_bad++; $display("FAIL 36_6 got done=%b q=%0d r=%0d dbz=%b want q=6 r=0 dbz=0", done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int cyc, bcyc, dones, a, b, want_cyc;
        logic [7:0] want_q;
        logic [3:0] want_r;
        logic       want_z;
        dones = 0;
        start = 1'b1; dividend = 8'd0; divisor = 4'd0;
        @(negedge clk);
        for (int idx = 0; idx < 4096; idx++) begin
            a = idx >> 4;
            b = idx & 15;
            if (idx < 4095) begin
                dividend = 8'((idx + 1) >> 4);
                divisor  = 4'((idx + 1) & 15);
            end else begin
                start = 1'b0;
            end
            wait_done(20, cyc, bcyc);
            if (done === 1'b1) dones++;
            if (b == 0) begin
                want_q = 8'hFF; want_r = 4'(a & 15); want_z = 1'b1; want_cyc = 1;
            end else begin
                want_q = 8'(a / b); want_r = 4'(a % b); want_z = 1'b0; want_cyc = 8;
            end
            n_cmp++;
            if (done !== 1'b1 || cyc != want_cyc || quotient !== want_q || remainder !== want_r || div_by_zero !== want_z) begin
                n_bad++;
                $display("FAIL exh_%0d_%0d got done=%b cyc=%0d q=%0d r=%0d dbz=%b want cyc=%0d q=%0d r=%0d dbz=%b",
                         a, b, done, cyc, quotient, remainder, div_by_zero, want_cyc, want_q, want_r, want_z);
            end
            @(negedge clk);
        end
        repeat (12) begin if (done === 1'b1) dones++; @(negedge clk); end
        n_cmp++; if (dones != 4096) begin n_bad++; $display("FAIL exh_done_count got %0d want 4096", dones); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset;
        test_basic;
        test_div_zero;
        test_start_while_busy;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
